sumaproductos_secuenciador: RTL

Synthesizable exhaustive-sweep controller for the sum-of-products lab datapath. It drives one shared stimulus vector into N_IMPL parallel implementations of the same boolean function. It compares every implementation's response against implementation 0 (the golden one) and accumulates mismatch statistics. It replaces free-running bench stimulus, so the lab can run self-checked on an FPGA board as well as in simulation.

---
 rtl/sumaproductos_pkg.sv | 12 +
 rtl/sumaproductos_comparador.sv | 14 +
 rtl/sumaproductos_secuenciador.sv | 114 +++++++++++
 3 files changed

// File: rtl/sumaproductos_pkg.sv
// Shared types and default widths for the sum-of-products lab sequencer and its implementations.
package sumaproductos_pkg;
    localparam int N_ENTRADAS_DEF = 4;
    localparam int N_IMPL_DEF     = 4;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        ESPERAR  = 2'd1,
        COMPARAR = 2'd2,
        FIN      = 2'd3
    } estado_t;
endpackage

// File: rtl/sumaproductos_comparador.sv
// Combinational comparison of every implementation's response against implementation 0.
module sumaproductos_comparador
    import sumaproductos_pkg::*;
#(
    parameter int N_IMPL = N_IMPL_DEF
) (
    input  logic [N_IMPL-1:0] Rtas,
    output logic [N_IMPL-1:0] m,
    output logic              any_mismatch
);
    // Bit 0 compares the golden response with itself, so it is always 0.
    assign m            = Rtas ^ {N_IMPL{Rtas[0]}};
    assign any_mismatch = |m;
endmodule

// File: rtl/sumaproductos_secuenciador.sv
// Exhaustive-sweep controller: drives every stimulus vector, compares responses, keeps mismatch statistics.
module sumaproductos_secuenciador
    import sumaproductos_pkg::*;
#(
    parameter int N_ENTRADAS = N_ENTRADAS_DEF,
    parameter int N_IMPL     = N_IMPL_DEF,
    parameter int SETTLE     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inicio,
    input  logic                  abortar,
    input  logic [N_IMPL-1:0]     Rtas,
    output logic [N_ENTRADAS-1:0] Estimulo,
    output logic                  ocupado,
    output logic                  fin,
    output logic                  hay_error,
    output logic [N_ENTRADAS:0]   cuenta_errores,
    output logic [N_ENTRADAS-1:0] primer_fallo,
    output logic [N_IMPL-1:0]     mascara_fallo
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    estado_t               estado_q;
    logic [CW-1:0]         cnt_q;
    logic [N_ENTRADAS-1:0] est_q;
    logic                  ocupado_q, fin_q, hay_q;
    logic [N_ENTRADAS:0]   cuenta_q;
    logic [N_ENTRADAS-1:0] primer_q;
    logic [N_IMPL-1:0]     mascara_q;

    logic [N_IMPL-1:0]     m;
    logic                  any_mm;

    sumaproductos_comparador #(.N_IMPL(N_IMPL)) u_comp (
        .Rtas         (Rtas),
        .m            (m),
        .any_mismatch (any_mm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= REPOSO;
            cnt_q     <= '0;
            est_q     <= '0;
            ocupado_q <= 1'b0;
            fin_q     <= 1'b0;
            hay_q     <= 1'b0;
            cuenta_q  <= '0;
            primer_q  <= '0;
            mascara_q <= '0;
        end else begin
            fin_q <= 1'b0;
            case (estado_q)
                REPOSO: begin
                    if (inicio) begin
                        est_q     <= '0;
                        cnt_q     <= '0;
                        hay_q     <= 1'b0;
                        cuenta_q  <= '0;
                        primer_q  <= '0;
                        mascara_q <= '0;
                        ocupado_q <= 1'b1;
                        estado_q  <= ESPERAR;
                    end
                end
                ESPERAR: begin
                    if (abortar) begin
                        est_q     <= '0;
                        ocupado_q <= 1'b0;
                        estado_q  <= REPOSO;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(SETTLE - 1)) estado_q <= COMPARAR;
                    end
                end
                COMPARAR: begin
                    // An abort on this edge discards the pending compare.
                    if (abortar) begin
                        est_q     <= '0;
                        ocupado_q <= 1'b0;
                        estado_q  <= REPOSO;
                    end else begin
                        if (any_mm) begin
                            cuenta_q  <= cuenta_q + (N_ENTRADAS+1)'(1);
                            mascara_q <= mascara_q | m;
                            hay_q     <= 1'b1;
                            if (!hay_q) primer_q <= est_q;
                        end
                        if (&est_q) begin
                            ocupado_q <= 1'b0;
                            fin_q     <= 1'b1;
                            estado_q  <= FIN;
                        end else begin
                            est_q    <= est_q + N_ENTRADAS'(1);
                            cnt_q    <= '0;
                            estado_q <= ESPERAR;
                        end
                    end
                end
                FIN:     estado_q <= REPOSO;
                default: estado_q <= REPOSO;
            endcase
        end
    end

    assign Estimulo       = est_q;
    assign ocupado        = ocupado_q;
    assign fin            = fin_q;
    assign hay_error      = hay_q;
    assign cuenta_errores = cuenta_q;
    assign primer_fallo   = primer_q;
    assign mascara_fallo  = mascara_q;
endmodule
